sync_fifo_flags: RTL
====================

Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO, next generation of the team's basic FIFO for memory-controller test benches and request queues. Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and defined simultaneous read/write behaviour. Data storage is a plain register array with no reset.

Parameters:
WIDTH, 8, data bus width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full_o asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty_o asserted when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_ni  input  1  asynchronous active-low reset
din_i  input  WIDTH  write data
wr_en_i  input  1  write request
rd_en_i  input  1  read request
clr_err_i  input  1  clears sticky error flags
dout_o  output  WIDTH  read data
rd_valid_o  output  1  dout_o updated this cycle (standard mode)
full_o  output  1  count == DEPTH
empty_o  output  1  count == 0
almost_full_o  output  1  count >= AF_THRESH
almost_empty_o  output  1  count <= AE_THRESH
count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow_o  output  1  sticky: write attempted while full
underflow_o  output  1  sticky: read attempted while empty

Behaviour:
- Clock clk_i; reset is asynchronous and active-low on reset_ni. Assertion immediately forces: pointers 0, count_o 0, empty_o 1, full_o 0, almost_empty_o 1, almost_full_o 0, dout_o 0, rd_valid_o 0, overflow_o 0, underflow_o 0. Memory contents not reset. Deassertion is synchronised externally.
- Pointers are ADDR_W+1 bits (ADDR_W = $clog2(DEPTH)). The low ADDR_W bits address the array; the MSB is the wrap bit. They wrap naturally modulo 2*DEPTH.
- Write accepted (wr_acc) = wr_en_i & !full_o. Array[wr_ptr] <= din_i and wr_ptr++.
- Read accepted (rd_acc) = rd_en_i & !empty_o. rd_ptr++.
- Standard mode: dout_o <= array[rd_ptr] and rd_valid_o <= 1 on the edge after rd_acc (1-cycle latency). Otherwise dout_o holds and rd_valid_o <= 0.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- All flags are registered and computed from next-state count, so they change in the same cycle as count_o.
- Full: a write is rejected even if a read is accepted in the same cycle. Count goes to DEPTH-1 and overflow_o sets. The source must retry.
- Empty: a read is rejected even if a write is accepted in the same cycle. Count goes to 1 and underflow_o sets.
- overflow_o sets on wr_en_i & full_o. underflow_o sets on rd_en_i & empty_o. Both hold until clr_err_i or reset. If set and clear coincide, set wins.
- Flag invariant: full_o and empty_o are never both 1. full_o == (wrap bits differ && address bits equal). empty_o == (pointers equal). count_o == wr_ptr - rd_ptr.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Defined (first-word fall-through): dout_o continuously presents array[rd_ptr] whenever !empty_o. rd_en_i acts as acknowledge, so head data is visible before the read. Data written to an empty FIFO appears on dout_o the cycle after the write edge, together with empty_o falling. rd_valid_o is tied to !empty_o.
- Undefined: standard registered-read mode as above.
- Count and flag behaviour is identical in both modes.

Decomposition:
- Package sync_fifo_pkg holds the clog2 function, derived ADDR_W/CNT_W constants and parameter-legality checks (power-of-two depth, threshold ranges) as elaboration asserts.
- One natural sub-module, sync_fifo_mem: WIDTH x DEPTH register array with one write port and one asynchronous read port, no reset. The top level holds pointers, count, flags and dout_o.

Test Plan (WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1):
- Reset mid-traffic: after 3 writes, pull reset_ni low between edges -> outputs reach reset values immediately (count_o=0, empty_o=1, dout_o=0); a subsequent write of 0xA5 and read returns 0xA5.
- Fill: 8 writes 0x00..0x07 -> almost_empty_o drops at count 2, almost_full_o rises at count 6, full_o=1 at count 8. A 9th write sets overflow_o; count_o stays 8.
- Drain: 8 reads after fill -> dout_o = 0x00..0x07 in order, each 1 cycle after its read, with rd_valid_o pulsing. A 9th read sets underflow_o; dout_o holds 0x07.
- Simultaneous: at count 4, assert wr_en_i and rd_en_i together for 20 cycles -> count_o stays 4, data order preserved across pointer wrap. At full with both asserted -> read accepted, write rejected, count 7, overflow_o=1.
- Error clear: with overflow_o=1, pulse clr_err_i -> 0 next cycle. clr_err_i coincident with a new overflow -> overflow_o remains 1.
- FWFT build: write 0x3C into empty FIFO -> next cycle empty_o=0 and dout_o=0x3C without rd_en_i. rd_en_i for one cycle -> empty_o=1, count_o=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and parameter-legality checks for sync_fifo_flags.
package sync_fifo_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = 1; v < value; v = v << 1) begin
      res++;
    end
    return res;
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic int unsigned addr_w(input int unsigned depth);
    return clog2(depth);
  endfunction

  // One extra bit so a count of exactly DEPTH is representable.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit depth_legal(input int unsigned depth);
    return is_pow2(depth) && (depth >= 2);
  endfunction

  function automatic bit af_legal(input int unsigned af, input int unsigned depth);
    return (af >= 1) && (af <= depth);
  endfunction

  function automatic bit ae_legal(input int unsigned ae, input int unsigned depth);
    return ae <= (depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [addr_w(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic [addr_w(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]           rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through output; default is registered read.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [WIDTH-1:0]          din_i,
  input  logic                      wr_en_i,
  input  logic                      rd_en_i,
  input  logic                      clr_err_i,
  output logic [WIDTH-1:0]          dout_o,
  output logic                      rd_valid_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      almost_full_o,
  output logic                      almost_empty_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output logic                      overflow_o,
  output logic                      underflow_o
);

  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned CNT_W  = cnt_w(DEPTH);

  localparam logic [ADDR_W:0]  PTR_INC  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two and >= 2");
  end
  if (!af_legal(AF_THRESH, DEPTH)) begin : g_bad_af
    $error("sync_fifo_flags: AF_THRESH must be in 1..DEPTH");
  end
  if (!ae_legal(AE_THRESH, DEPTH)) begin : g_bad_ae
    $error("sync_fifo_flags: AE_THRESH must be in 0..DEPTH-1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_flags: WIDTH must be >= 1");
  end

  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rdata;

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (din_i),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

  // Occupancy comes from the pointer difference (wrap bit included), so a
  // simultaneous accepted read and write leaves it unchanged by construction.
  always_comb begin
    wr_acc   = wr_en_i & ~full_q;
    rd_acc   = rd_en_i & ~empty_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_INC : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PTR_INC : rd_ptr_q;
    count_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (count_d == CNT_FULL);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CNT_AF);
    aempty_d = (count_d <= CNT_AE);
    ovf_d    = (wr_en_i & full_q)  | (ovf_q & ~clr_err_i);
    udf_d    = (rd_en_i & empty_q) | (udf_q & ~clr_err_i);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout_o     = empty_q ? '0 : mem_rdata;
  assign rd_valid_o = ~empty_q;
`else
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    dout_d     = rd_acc ? mem_rdata : dout_q;
    rd_valid_d = rd_acc;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign dout_o     = dout_q;
  assign rd_valid_o = rd_valid_q;
`endif

  assign count_o        = wr_ptr_q - rd_ptr_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule
